// File: rtl/aes_decrypt_core.sv
// aes_decrypt_core -- iterative AES-128 inverse cipher (FIPS-197).
//
// Ports
//   clk                         : single clock, rising edge
//   rst                         : synchronous, active-low reset
//   start                       : request decryption (ignored while busy)
//   cipher_text0..cipher_text3  : ciphertext words, byte 4n in [31:24] of word n
//   cipher_key0..cipher_key3    : AES-128 key words, same byte order
//   plain_text0..plain_text3    : recovered plaintext words (held in DONE)
//   plain_valid                 : result valid, cleared by the next accepted start
//   busy                        : high in EXPAND, WHITEN and ROUND
//
// Operation: the forward key schedule runs for 10 cycles to reach round key 10,
// one cycle whitens the state with it, then 10 inverse rounds walk the key
// schedule backwards, one round key per cycle. Latency is 21 edges.
//
// Optional build macro: AES_DEC_KEY_CACHE_EN keeps the last expanded key and its
// round key 10; a start with the same key skips EXPAND (latency 11 edges).
module aes_decrypt_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] cipher_text0,
  input  logic [31:0] cipher_text1,
  input  logic [31:0] cipher_text2,
  input  logic [31:0] cipher_text3,
  input  logic [31:0] cipher_key0,
  input  logic [31:0] cipher_key1,
  input  logic [31:0] cipher_key2,
  input  logic [31:0] cipher_key3,
  output logic [31:0] plain_text0,
  output logic [31:0] plain_text1,
  output logic [31:0] plain_text2,
  output logic [31:0] plain_text3,
  output logic        plain_valid,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, EXPAND, WHITEN, ROUND, DONE} state_t;

  // Tables are stored entry 0 first (most significant byte).
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entry x sits at bit offset 8*(255-x); ~x is 255-x for an 8-bit x.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SBOX[idx +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return INV_SBOX[idx +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // SubWord(RotWord(w)) xor Rcon, shared by both key schedule directions.
  function automatic logic [31:0] key_core(input logic [31:0] w, input logic [7:0] rc);
    return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ key_core(k[31:0], rc);
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo one forward step: the last three words unwind by xor, then the
  // first word needs the core applied to the recovered last word.
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0] ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ key_core(p3, rc);
    return {p0, p1, p2, p3};
  endfunction

  // InvShiftRows fused with InvSubBytes: row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(15-(4*c+r)) +: 8] = inv_sbox(s[8*(15-(4*((c-r+4)%4)+r)) +: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[8*(3-i) +: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[32*(3-c) +: 32] = inv_mix_col(s[32*(3-c) +: 32]);
    end
    return o;
  endfunction

  state_t        st, st_nxt;
  logic [127:0]  state_q;
  logic [127:0]  rk_q;
  logic [7:0]    rcon_q;
  logic [3:0]    cnt_q;

  logic [127:0]  key_in, ct_in;
  logic [127:0]  rk_fwd, rk_prev, round_add, round_out;
  logic [127:0]  rk_load;
  logic          accept, cache_hit;

  assign key_in = {cipher_key0, cipher_key1, cipher_key2, cipher_key3};
  assign ct_in  = {cipher_text0, cipher_text1, cipher_text2, cipher_text3};
  assign accept = start && ((st == IDLE) || (st == DONE));

  // In ROUND, rk_q holds key cnt_q+1; the key for this round is derived here.
  assign rk_fwd    = key_fwd(rk_q, rcon_q);
  assign rk_prev   = key_inv(rk_q, rcon_of(cnt_q + 4'd1));
  assign round_add = inv_shift_sub(state_q) ^ rk_prev;
  assign round_out = (cnt_q == 4'd0) ? round_add : inv_mix(round_add);

`ifdef AES_DEC_KEY_CACHE_EN
  logic          cache_vld_q;
  logic [127:0]  cache_key_q;
  logic [127:0]  cache_rk10_q;

  assign cache_hit = cache_vld_q && (key_in == cache_key_q);
  assign rk_load   = cache_hit ? cache_rk10_q : key_in;

  // The key is recorded at accept but only trusted once its expansion completes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cache_vld_q  <= 1'b0;
      cache_key_q  <= '0;
      cache_rk10_q <= '0;
    end else if (accept && !cache_hit) begin
      cache_key_q <= key_in;
      cache_vld_q <= 1'b0;
    end else if ((st == EXPAND) && (cnt_q == 4'd9)) begin
      cache_rk10_q <= rk_fwd;
      cache_vld_q  <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign rk_load   = key_in;
`endif

  always_ff @(posedge clk) begin
    if (!rst) st <= IDLE;
    else      st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    busy   = 1'b0;
    case (st)
      IDLE, DONE: begin
        if (start) st_nxt = cache_hit ? WHITEN : EXPAND;
      end
      EXPAND: begin
        busy = 1'b1;
        if (cnt_q == 4'd9) st_nxt = WHITEN;
      end
      WHITEN: begin
        busy   = 1'b1;
        st_nxt = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (cnt_q == 4'd0) st_nxt = DONE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= '0;
      rk_q        <= '0;
      rcon_q      <= '0;
      cnt_q       <= '0;
      plain_text0 <= '0;
      plain_text1 <= '0;
      plain_text2 <= '0;
      plain_text3 <= '0;
      plain_valid <= 1'b0;
    end else begin
      case (st)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= ct_in;
            rk_q        <= rk_load;
            rcon_q      <= 8'h01;
            cnt_q       <= 4'd0;
            plain_valid <= 1'b0;
          end
        end
        EXPAND: begin
          rk_q   <= rk_fwd;
          rcon_q <= xtime(rcon_q);
          cnt_q  <= cnt_q + 4'd1;
        end
        WHITEN: begin
          state_q <= state_q ^ rk_q;
          cnt_q   <= 4'd9;
        end
        ROUND: begin
          state_q <= round_out;
          rk_q    <= rk_prev;
          cnt_q   <= cnt_q - 4'd1;
          if (cnt_q == 4'd0) begin
            {plain_text0, plain_text1, plain_text2, plain_text3} <= round_out;
            plain_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// tb_aes_decrypt_core -- self-checking bench for aes_decrypt_core.
// A reference model derives the S-boxes from GF(2^8) inversion plus the affine
// map and decrypts with a fully expanded forward key schedule; a cycle model
// tracks busy / plain_valid / plain_text and is compared on every falling edge.
module tb_aes_decrypt_core;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] ct0, ct1, ct2, ct3, k0, k1, k2, k3;
  logic [31:0] pt0, pt1, pt2, pt3;
  logic        plain_valid, busy;

  always #5 clk = ~clk;

  aes_decrypt_core dut (
    .clk(clk), .rst(rst), .start(start),
    .cipher_text0(ct0), .cipher_text1(ct1), .cipher_text2(ct2), .cipher_text3(ct3),
    .cipher_key0(k0), .cipher_key1(k1), .cipher_key2(k2), .cipher_key3(k3),
    .plain_text0(pt0), .plain_text1(pt1), .plain_text2(pt2), .plain_text3(pt3),
    .plain_valid(plain_valid), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] aes_dec(input logic [127:0] key, input logic [127:0] ct);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  rc;
    logic [31:0] tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ w[40+i/4][31-8*(i%4) -: 8];
    for (int r = 9; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*c+row] = isb[s[4*((c-row+4)%4)+row]];
      for (int i = 0; i < 16; i++) t[i] ^= w[4*r+i/4][31-8*(i%4) -: 8];
      if (r > 0) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c+0] = gm(t[4*c], 8'h0e) ^ gm(t[4*c+1], 8'h0b) ^ gm(t[4*c+2], 8'h0d) ^ gm(t[4*c+3], 8'h09);
          s[4*c+1] = gm(t[4*c], 8'h09) ^ gm(t[4*c+1], 8'h0e) ^ gm(t[4*c+2], 8'h0b) ^ gm(t[4*c+3], 8'h0d);
          s[4*c+2] = gm(t[4*c], 8'h0d) ^ gm(t[4*c+1], 8'h09) ^ gm(t[4*c+2], 8'h0e) ^ gm(t[4*c+3], 8'h0b);
          s[4*c+3] = gm(t[4*c], 8'h0b) ^ gm(t[4*c+1], 8'h0d) ^ gm(t[4*c+2], 8'h09) ^ gm(t[4*c+3], 8'h0e);
        end
      end else begin
        s = t;
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- cycle-level expectation ----------------
  logic         m_busy = 1'b0, m_valid = 1'b0, m_cvld = 1'b0;
  logic [127:0] m_pt = '0, m_pend = '0, m_ckey = '0;
  int           m_left = 0;

  function automatic bit model_hit(input logic [127:0] k);
    return CACHE && m_cvld && (k == m_ckey);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_pt <= '0; m_left <= 0; m_cvld <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0; m_valid <= 1'b1; m_pt <= m_pend; m_cvld <= CACHE;
      end
    end else if (start) begin
      m_busy  <= 1'b1;
      m_valid <= 1'b0;
      m_pend  <= aes_dec({k0, k1, k2, k3}, {ct0, ct1, ct2, ct3});
      m_left  <= model_hit({k0, k1, k2, k3}) ? 11 : 21;
      if (!model_hit({k0, k1, k2, k3})) begin
        m_ckey <= {k0, k1, k2, k3};
        m_cvld <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 128'(busy), 128'(m_busy));
      chk("plain_valid", 128'(plain_valid), 128'(m_valid));
      if (!m_busy) chk("plain_text", {pt0, pt1, pt2, pt3}, m_pt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic [127:0] key, input logic [127:0] ct);
    {k0, k1, k2, k3} = key;
    {ct0, ct1, ct2, ct3} = ct;
  endtask

  // mode 0: start pulse only; 1: extra pulses at +3 and +15; 2: start held high
  task automatic run_op(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] exp_pt,
                        input int exp_lat, input int mode, input string nm);
    int lat;
    lat = 0;
    @(negedge clk);
    set_in(key, ct);
    start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = (mode == 2) || ((mode == 1) && (i == 3 || i == 15));
      set_in({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      @(posedge clk);
      #1;
      if (plain_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk({nm, "_latency"}, 128'(lat), 128'(exp_lat));
    chk({nm, "_result"}, {pt0, pt1, pt2, pt3}, exp_pt);
  endtask

  task automatic reset_mid(input logic [127:0] key, input logic [127:0] ct, input int at);
    @(negedge clk);
    set_in(key, ct);
    start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= at; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == at) rst = 1'b0;
      @(posedge clk);
    end
    #1;
    chk("rst_mid_busy", 128'(busy), 128'(0));
    chk("rst_mid_valid", 128'(plain_valid), 128'(0));
    chk("rst_mid_text", {pt0, pt1, pt2, pt3}, 128'(0));
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [127:0] key, ct, last_key;
    rst = 1'b0;
    start = 1'b0;
    set_in('0, '0);
    build_sbox();
    chk("model_appB", aes_dec(KB, CB), PB);
    chk("model_appC1", aes_dec(KC, CC), PC);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_valid", 128'(plain_valid), 128'(0));
    chk("reset_text", {pt0, pt1, pt2, pt3}, 128'(0));
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;

    run_op(KB, CB, PB, 21, 0, "appB");
    run_op(KC, CC, PC, 21, 0, "appC1");
    run_op(KB, CB, PB, 21, 1, "appB_start_pulses");
    reset_mid(KC, CC, 12);
    run_op(KB, CB, PB, 21, 0, "appB_after_reset");
    run_op(KB, CB, PB, CACHE ? 11 : 21, 2, "b2b_first");
    run_op(KC, CC, PC, 21, 2, "b2b_second");
    run_op(KB, CB, PB, 21, 0, "appB_new_key");
    run_op(KB, CB, PB, CACHE ? 11 : 21, 0, "appB_repeat_key");

    last_key = KB;
    for (int n = 0; n < 24; n++) begin
      key = ($urandom_range(0, 2) == 0) ? last_key : {$urandom, $urandom, $urandom, $urandom};
      ct  = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 5) == 0) begin
        reset_mid(key, ct, $urandom_range(1, 20));
      end else begin
        run_op(key, ct, aes_dec(key, ct), model_hit(key) ? 11 : 21, $urandom_range(0, 2), "random");
        last_key = key;
      end
    end

    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
